// File: rtl/aes_stream_pkg.sv
// ---------------------------------------------------------------------------
// aes_stream_pkg
//   Shared definitions for the AES accelerator's word/block streaming logic.
//   Provides the word and block widths, their typedefs, the collector FSM
//   state encoding and a helper that shifts one word into a block accumulator.
// ---------------------------------------------------------------------------
package aes_stream_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

    // Count value held just before the word that completes a block arrives.
    localparam logic [2:0] LAST_WORD_COUNT = 3'(WORDS_PER_BLOCK - 1);
    // Count value held while a full block waits in the accumulator.
    localparam logic [2:0] FULL_COUNT      = 3'(WORDS_PER_BLOCK);

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } collector_state_t;

    // msb_first=1: the oldest word migrates toward the top of the block.
    // msb_first=0: the oldest word migrates toward the bottom of the block.
    function automatic block_t shift_in(input block_t acc, input word_t word,
                                        input bit msb_first);
        block_t result;
        if (msb_first) begin
            result = {acc[BLOCK_W-WORD_W-1:0], word};
        end else begin
            result = {word, acc[BLOCK_W-1:WORD_W]};
        end
        return result;
    endfunction

endpackage

// File: rtl/flexbyte_stp_collector.sv
// ---------------------------------------------------------------------------
// flexbyte_stp_collector
//   Serial-to-parallel collector: accepts 32-bit words over a valid/ready
//   input and assembles every four of them into a 128-bit block presented on
//   a valid/ready output. One complete block can wait in the accumulator
//   while the previously presented block is still unconsumed.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both 1. The source keeps data stable while valid=1
//   and ready=0; ready may depend on state but never on the partner's valid.
//
// Ports
//   clk        in   1    system clock, rising edge
//   n_rst      in   1    synchronous active-low reset
//   clear      in   1    synchronous flush of partial and pending blocks
//   in_valid   in   1    data_in carries a word
//   in_ready   out  1    collector accepts a word this cycle
//   data_in    in   32   input word
//   out_valid  out  1    data_out holds a complete block
//   out_ready  in   1    consumer takes data_out this cycle
//   data_out   out  128  assembled block
//   word_count out  3    words held in the accumulator (0..4)
//
// Parameter
//   MSB  1: first word received lands in data_out[127:96]
//        0: first word received lands in data_out[31:0]
// ---------------------------------------------------------------------------
module flexbyte_stp_collector
    import aes_stream_pkg::*;
#(
    parameter bit MSB = 1'b1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic [2:0]   word_count
);

    collector_state_t state;
    block_t           acc;
    block_t           shifted;
    logic             in_fire;
    logic             out_fire;
    logic             completes;
    logic             out_free;

    // Accepting only in COLLECT guarantees no word arrives while a full block
    // waits in the accumulator. Reset forces the input closed immediately.
    assign in_ready  = n_rst && (state == COLLECT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign shifted   = shift_in(acc, data_in, MSB);
    assign completes = in_fire && (word_count == LAST_WORD_COUNT);
    // The output register can take a new block if it is empty or being
    // drained on this same edge; that is what allows one block per 4 cycles.
    assign out_free  = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= COLLECT;
            acc        <= '0;
            data_out   <= '0;
            word_count <= '0;
            out_valid  <= 1'b0;
        end else if (clear) begin
            // Words presented during clear are dropped; acc and data_out are
            // left as they are since nothing valid refers to them afterwards.
            state      <= COLLECT;
            word_count <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_fire) begin
                        acc <= shifted;
                    end

                    if (completes) begin
                        if (out_free) begin
                            data_out   <= shifted;
                            out_valid  <= 1'b1;
                            word_count <= '0;
                        end else begin
                            // Output still occupied: park the block in acc.
                            word_count <= FULL_COUNT;
                            state      <= STALL;
                        end
                    end else begin
                        if (in_fire) begin
                            word_count <= word_count + 3'd1;
                        end
                        if (out_fire) begin
                            out_valid <= 1'b0;
                        end
                    end
                end

                STALL: begin
                    // out_valid is always 1 here; the parked block replaces
                    // the consumed one without a gap in out_valid.
                    if (out_fire) begin
                        data_out   <= acc;
                        word_count <= '0;
                        state      <= COLLECT;
                    end
                end

                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flexbyte_stp_collector.sv
module tb_flexbyte_stp_collector;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         in_valid;
    logic [31:0]  data_in;
    logic         out_ready;

    logic         in_ready_1, out_valid_1;
    logic [127:0] data_out_1;
    logic [2:0]   word_count_1;
    logic         in_ready_0, out_valid_0;
    logic [127:0] data_out_0;
    logic [2:0]   word_count_0;

    int n_chk;
    int n_fail;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    flexbyte_stp_collector #(.MSB(1'b1)) dut_msb (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready_1),
        .data_in    (data_in),
        .out_valid  (out_valid_1),
        .out_ready  (out_ready),
        .data_out   (data_out_1),
        .word_count (word_count_1)
    );

    flexbyte_stp_collector #(.MSB(1'b0)) dut_lsb (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready_0),
        .data_in    (data_in),
        .out_valid  (out_valid_0),
        .out_ready  (out_ready),
        .data_out   (data_out_0),
        .word_count (word_count_0)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and checks happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        in_valid = 1'b1;
        data_in  = w;
        step();
        in_valid = 1'b0;
    endtask

    // Watchdog: the directed sequence is a fixed number of cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected end of sequence");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] a, b, c, d;
        n_chk = 0;
        n_fail = 0;
        n_rst = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        data_in = '0;
        out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 128'(in_ready_1), 128'd0);
        chk("rst_out_valid", 128'(out_valid_1), 128'd0);
        chk("rst_word_count", 128'(word_count_1), 128'd0);
        chk("rst_data_out", data_out_1, 128'd0);
        n_rst = 1'b1;
        step();
        chk("post_rst_in_ready", 128'(in_ready_1), 128'd1);
        chk("post_rst_out_valid", 128'(out_valid_1), 128'd0);

        // Basic block, both word orders, out_ready=1
        send(32'h00112233);
        chk("b1_wc1", 128'(word_count_1), 128'd1);
        send(32'h44556677);
        send(32'h8899AABB);
        chk("b1_no_early_valid", 128'(out_valid_1), 128'd0);
        chk("b1_wc3", 128'(word_count_1), 128'd3);
        send(32'hCCDDEEFF);
        chk("b1_valid", 128'(out_valid_1), 128'd1);
        chk("b1_data_msb", data_out_1, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("b1_data_lsb", data_out_0, 128'hCCDDEEFF_8899AABB_44556677_00112233);
        chk("b1_wc0", 128'(word_count_1), 128'd0);
        step();
        chk("b1_drained", 128'(out_valid_1), 128'd0);

        // Backpressure: 8 words with out_ready=0
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k >= 5) chk($sformatf("bp_in_ready_w%0d", k), 128'(in_ready_1), 128'd1);
            send(32'h1000_0000 + 32'(k));
            if (k == 4) begin
                chk("bp_blk1_valid", 128'(out_valid_1), 128'd1);
                chk("bp_blk1_data", data_out_1,
                    {32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004});
            end
        end
        chk("bp_stall_in_ready", 128'(in_ready_1), 128'd0);
        chk("bp_stall_wc4", 128'(word_count_1), 128'd4);
        chk("bp_held_data", data_out_1,
            {32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004});
        // Offer a word during stall; it must not be taken.
        in_valid = 1'b1;
        data_in  = 32'hFFFF_0000;
        step();
        in_valid = 1'b0;
        chk("bp_stall_hold_wc", 128'(word_count_1), 128'd4);
        chk("bp_stall_hold_valid", 128'(out_valid_1), 128'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_blk2_valid", 128'(out_valid_1), 128'd1);
        chk("bp_blk2_data", data_out_1,
            {32'h10000005, 32'h10000006, 32'h10000007, 32'h10000008});
        chk("bp_blk2_data_lsb", data_out_0,
            {32'h10000008, 32'h10000007, 32'h10000006, 32'h10000005});
        chk("bp_in_ready_back", 128'(in_ready_1), 128'd1);
        chk("bp_wc0", 128'(word_count_1), 128'd0);
        step();
        chk("bp_blk2_stable", data_out_1,
            {32'h10000005, 32'h10000006, 32'h10000007, 32'h10000008});
        out_ready = 1'b1;
        step();
        chk("bp_blk2_drained", 128'(out_valid_1), 128'd0);

        // Clear with a pending block and 2 partial words
        out_ready = 1'b0;
        send(32'h2000_0001);
        send(32'h2000_0002);
        send(32'h2000_0003);
        send(32'h2000_0004);
        send(32'hDEAD_0001);
        send(32'hDEAD_0002);
        chk("clr_pre_valid", 128'(out_valid_1), 128'd1);
        chk("clr_pre_wc", 128'(word_count_1), 128'd2);
        clear = 1'b1;
        in_valid = 1'b1;
        data_in = 32'hBAD0_BAD0;
        #1;
        chk("clr_in_ready", 128'(in_ready_1), 128'd1);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", 128'(out_valid_1), 128'd0);
        chk("clr_wc", 128'(word_count_1), 128'd0);
        out_ready = 1'b1;
        a = 32'hA1A2A3A4; b = 32'hB1B2B3B4; c = 32'hC1C2C3C4; d = 32'hD1D2D3D4;
        send(a);
        send(b);
        send(c);
        chk("clr_no_residue_valid", 128'(out_valid_1), 128'd0);
        send(d);
        chk("clr_blk_valid", 128'(out_valid_1), 128'd1);
        chk("clr_blk_msb", data_out_1, {a, b, c, d});
        chk("clr_blk_lsb", data_out_0, {d, c, b, a});
        step();

        // Reset mid-block
        send(32'h3000_0001);
        send(32'h3000_0002);
        send(32'h3000_0003);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_in_ready_comb", 128'(in_ready_1), 128'd0);
        step();
        chk("mid_rst_out_valid", 128'(out_valid_1), 128'd0);
        chk("mid_rst_wc", 128'(word_count_1), 128'd0);
        chk("mid_rst_data_out", data_out_1, 128'd0);
        n_rst = 1'b1;
        step();
        send(32'h4000_0001);
        chk("mid_rst_wc_fresh", 128'(word_count_1), 128'd1);
        send(32'h4000_0002);
        send(32'h4000_0003);
        chk("mid_rst_no_residue_blk", 128'(out_valid_1), 128'd0);
        send(32'h4000_0004);
        chk("mid_rst_blk_valid", 128'(out_valid_1), 128'd1);
        chk("mid_rst_blk", data_out_1,
            {32'h40000001, 32'h40000002, 32'h40000003, 32'h40000004});
        step();
        chk("mid_rst_single_blk", 128'(out_valid_1), 128'd0);

        // Idle bubbles: in_valid toggles, junk data on idle cycles
        send(32'h00112233);
        data_in = 32'hEEEE_0001; step();
        send(32'h44556677);
        data_in = 32'hEEEE_0002; step();
        send(32'h8899AABB);
        data_in = 32'hEEEE_0003; step();
        chk("bub_wc3", 128'(word_count_1), 128'd3);
        chk("bub_no_early_valid", 128'(out_valid_1), 128'd0);
        send(32'hCCDDEEFF);
        chk("bub_blk_valid", 128'(out_valid_1), 128'd1);
        chk("bub_blk_msb", data_out_1, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("bub_blk_lsb", data_out_0, 128'hCCDDEEFF_8899AABB_44556677_00112233);
        data_in = 32'hEEEE_0004; step();
        chk("bub_single_blk", 128'(out_valid_1), 128'd0);
        chk("bub_wc0", 128'(word_count_1), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
